// File: rtl/axi4_pkg.sv
// Shared types and constants for the AXI4 burst slaves: burst encodings,
// response codes and the read-channel state machine states.
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } t_burst;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } t_rd_state;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_slave_read_burst_if.sv
// AXI4 read address and read data channels between interconnect and slave.
// Every channel transfers on the rising edge where VALID and READY are both
// high; a source keeps VALID and its payload stable until that edge.
interface axi4_slave_read_burst_if #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4
);
    logic                      AR_VALID;
    logic [AXI_ID_WIDTH-1:0]   AR_ID;
    logic [AXI_ADDR_WIDTH-1:0] AR_ADDR;
    logic [7:0]                AR_LEN;
    logic [2:0]                AR_SIZE;
    logic [1:0]                AR_BURST;
    logic [2:0]                AR_PROT;
    logic                      AR_READY;

    logic                      R_READY;
    logic [AXI_ID_WIDTH-1:0]   R_ID;
    logic [AXI_DATA_WIDTH-1:0] R_DATA;
    logic [1:0]                R_RESP;
    logic                      R_LAST;
    logic                      R_VALID;

    modport slave (
        input  AR_VALID, AR_ID, AR_ADDR, AR_LEN, AR_SIZE, AR_BURST, AR_PROT, R_READY,
        output AR_READY, R_ID, R_DATA, R_RESP, R_LAST, R_VALID
    );

    modport master (
        output AR_VALID, AR_ID, AR_ADDR, AR_LEN, AR_SIZE, AR_BURST, AR_PROT, R_READY,
        input  AR_READY, R_ID, R_DATA, R_RESP, R_LAST, R_VALID
    );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Combinational AXI4 burst address arithmetic: step alignment of an address
// and the address of the following beat for FIXED, INCR and WRAP bursts.
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    input  logic [2:0]                size,
    input  logic [7:0]                len,
    input  t_burst                    burst,
    output logic [AXI_ADDR_WIDTH-1:0] aligned_addr,
    output logic [AXI_ADDR_WIDTH-1:0] next_addr
);
    logic [AXI_ADDR_WIDTH-1:0] step;
    logic [AXI_ADDR_WIDTH-1:0] container;
    logic [AXI_ADDR_WIDTH-1:0] wrap_mask;
    logic [AXI_ADDR_WIDTH-1:0] wrap_base;
    logic [AXI_ADDR_WIDTH-1:0] incr_addr;

    always_comb begin
        step         = AXI_ADDR_WIDTH'(1) << size;
        container    = (AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) << size;
        wrap_mask    = container - AXI_ADDR_WIDTH'(1);
        wrap_base    = addr & ~wrap_mask;
        incr_addr    = addr + step;
        aligned_addr = addr & ~(step - AXI_ADDR_WIDTH'(1));
        next_addr    = addr;
        case (burst)
            INCR:    next_addr = incr_addr;
            // Low bits roll over inside the container, high bits stay at its base.
            WRAP:    next_addr = wrap_base | (incr_addr & wrap_mask);
            default: next_addr = addr;
        endcase
    end
endmodule

// File: rtl/axi4_slave_read_burst.sv
// AXI4 read slave: takes one AR burst at a time and turns each beat into a
// request/grant/rvalid exchange on a simple memory port, returning R beats.
module axi4_slave_read_burst
    import axi4_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    axi4_slave_read_burst_if.slave    axi,
    output logic                      mem_req_o,
    output logic [AXI_ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [AXI_DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                      mem_err_i,
    output t_rd_state                 state_o
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

    t_rd_state                 state_q, state_nxt;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q;
    logic [2:0]                size_q;
    t_burst                    burst_q;
    logic [7:0]                cnt_q;
    logic                      err_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                resp_q;

    logic                      ar_hs;
    logic                      r_hs;
    logic                      last_beat;
    logic                      ar_illegal;
    t_burst                    ar_burst;

    logic [AXI_ADDR_WIDTH-1:0] gen_addr;
    logic [2:0]                gen_size;
    logic [7:0]                gen_len;
    t_burst                    gen_burst;
    logic [AXI_ADDR_WIDTH-1:0] aligned_addr;
    logic [AXI_ADDR_WIDTH-1:0] next_addr;

    logic                      unused_prot;

    assign unused_prot = ^axi.AR_PROT;
    assign ar_burst    = t_burst'(axi.AR_BURST);
    assign ar_hs       = axi.AR_VALID & axi.AR_READY;
    assign r_hs        = axi.R_VALID & axi.R_READY;
    assign last_beat   = (cnt_q == len_q);
    assign ar_illegal  = (axi.AR_SIZE > MAX_SIZE) || (ar_burst == RSVD) ||
                         ((ar_burst == WRAP) && !wrap_len_ok(axi.AR_LEN));

    // In IDLE the generator aligns the incoming WRAP start address; otherwise
    // it advances the latched beat address.
    always_comb begin
        gen_addr  = addr_q;
        gen_size  = size_q;
        gen_len   = len_q;
        gen_burst = burst_q;
        if (state_q == IDLE) begin
            gen_addr  = axi.AR_ADDR;
            gen_size  = axi.AR_SIZE;
            gen_len   = axi.AR_LEN;
            gen_burst = ar_burst;
        end
    end

    axi4_burst_addr_gen #(
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)
    ) u_addr_gen (
        .addr        (gen_addr),
        .size        (gen_size),
        .len         (gen_len),
        .burst       (gen_burst),
        .aligned_addr(aligned_addr),
        .next_addr   (next_addr)
    );

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: if (ar_hs) state_nxt = ar_illegal ? RESP : REQ;
            REQ:  if (mem_gnt_i) state_nxt = WAIT;
            WAIT: if (mem_rvalid_i) state_nxt = RESP;
            // Illegal bursts stay in RESP and emit SLVERR beats without memory access.
            RESP: if (r_hs) state_nxt = last_beat ? IDLE : (err_q ? RESP : REQ);
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= FIXED;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_nxt;
            case (state_q)
                IDLE: begin
                    if (ar_hs) begin
                        id_q    <= axi.AR_ID;
                        addr_q  <= (ar_burst == WRAP) ? aligned_addr : axi.AR_ADDR;
                        len_q   <= axi.AR_LEN;
                        size_q  <= axi.AR_SIZE;
                        burst_q <= ar_burst;
                        cnt_q   <= '0;
                        err_q   <= ar_illegal;
                        rdata_q <= '0;
                        resp_q  <= ar_illegal ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        rdata_q <= mem_rdata_i;
                        resp_q  <= mem_err_i ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                RESP: begin
                    if (r_hs && !last_beat) begin
                        cnt_q  <= cnt_q + 8'd1;
                        addr_q <= next_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // AR_READY is masked while reset is held so every output reads zero then.
    assign axi.AR_READY = (state_q == IDLE) && !arst_i;
    assign axi.R_VALID  = (state_q == RESP);
    assign axi.R_LAST   = (state_q == RESP) && last_beat;
    assign axi.R_ID     = id_q;
    assign axi.R_DATA   = rdata_q;
    assign axi.R_RESP   = resp_q;
    assign mem_req_o    = (state_q == REQ);
    assign mem_addr_o   = addr_q;
    assign state_o      = state_q;
endmodule
